// File: rtl/pipelined_rca_adder.sv
// pipelined_rca_adder: WIDTH-bit add/subtract built from CHUNK-bit
// ripple slices, one slice per stage, with valid/ready flow control.
module pipelined_rca_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int STAGES = WIDTH / CHUNK;

   if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("WIDTH must be a positive multiple of CHUNK");
   end

   logic en;
   logic ovf_d;
   logic ovf_q;

   // whole pipe advances unless the output beat is blocked
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * CHUNK;
      localparam int HI = LO + CHUNK;

      logic              v_in;
      logic              c_in;
      logic [WIDTH-1:LO] a_in;
      logic [WIDTH-1:LO] b_in;
      logic [CHUNK-1:0]  r;
      logic              c_d;
      logic [HI-1:0]     s_d;
      logic              vld_q;
      logic              cy_q;
      logic [HI-1:0]     s_q;

      if (k == 0) begin : g_src
         assign v_in = in_valid;
         assign c_in = sub ^ cin;
         assign a_in = a;
         assign b_in = sub ? ~b : b;
         assign s_d  = r;
      end else begin : g_src
         logic [WIDTH-1:LO] a_q;
         logic [WIDTH-1:LO] b_q;

         // skew: upper operand chunks follow the beat down the pipe
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en) begin
               a_q <= g_st[k-1].a_in[WIDTH-1:LO];
               b_q <= g_st[k-1].b_in[WIDTH-1:LO];
            end
         end

         assign v_in = g_st[k-1].vld_q;
         assign c_in = g_st[k-1].cy_q;
         assign a_in = a_q;
         assign b_in = b_q;
         assign s_d  = {r, g_st[k-1].s_q};
      end

      // ripple-carry across this stage's chunk
      always_comb begin : p_rca
         logic c;
         c = c_in;
         r = '0;
         for (int j = 0; j < CHUNK; j++) begin
            r[j] = a_in[LO+j] ^ b_in[LO+j] ^ c;
            c    = (a_in[LO+j] & b_in[LO+j])
                 | (c & (a_in[LO+j] ^ b_in[LO+j]));
         end
         c_d = c;
      end

      // stage valid, chunk carry and deskewed low sum bits
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            s_q   <= '0;
         end else if (en) begin
            vld_q <= v_in;
            cy_q  <= c_d;
            s_q   <= s_d;
         end
      end
   end

   // carry into the MSB is recovered as a ^ b ^ sum at that bit
   assign ovf_d = g_st[STAGES-1].a_in[WIDTH-1]
                ^ g_st[STAGES-1].b_in[WIDTH-1]
                ^ g_st[STAGES-1].r[CHUNK-1]
                ^ g_st[STAGES-1].c_d;

   // signed overflow registered alongside the last stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = g_st[STAGES-1].vld_q;
   assign sum       = g_st[STAGES-1].s_q;
   assign cout      = g_st[STAGES-1].cy_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// tb_pipelined_rca_adder: directed and random beats, scoreboard of
// expected results, latency, backpressure and mid-stream reset.
module tb_pipelined_rca_adder;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   exp_t sbq[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   run_q   = 0;
   int   max_run = 0;

   pipelined_rca_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [15:0] s,
                               input logic c, input logic o);
      exp_t e;
      e.s = s;
      e.c = c;
      e.o = o;
      return e;
   endfunction

   function automatic exp_t model(input logic [15:0] x,
                                  input logic [15:0] y,
                                  input logic ci, input logic sb);
      logic [15:0] ye;
      logic        ce;
      logic [16:0] r;
      exp_t        e;
      ye  = sb ? ~y : y;
      ce  = sb ? ~ci : ci;
      r   = {1'b0, x} + {1'b0, ye} + {16'd0, ce};
      e.s = r[15:0];
      e.c = r[16];
      e.o = (x[15] == ye[15]) && (r[15] != x[15]);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // drive one beat, push its expected result when it is taken
   task automatic put(input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, input logic is,
                      input exp_t e);
      int t;
      a        = ia;
      b        = ib;
      cin      = ic;
      sub      = is;
      in_valid = 1'b1;
      t        = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && t < 50) begin
         t++;
         @(negedge clk);
      end
      chk("accept", {31'd0, in_ready}, 32'd1);
      if (in_ready === 1'b1) sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic put_rand();
      logic [15:0] x;
      logic [15:0] y;
      logic        ci;
      logic        sb;
      x  = 16'($urandom);
      y  = 16'($urandom);
      ci = 1'($urandom);
      sb = 1'($urandom);
      put(x, y, ci, sb, model(x, y, ci, sb));
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 40) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_empty", sbq.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // single beat into an empty pipe must surface exactly 4 edges on
   task automatic lat_beat(input logic [15:0] ia, input logic [15:0] ib,
                           input logic ic, input logic is,
                           input exp_t e);
      put(ia, ib, ic, is, e);
      in_valid = 1'b0;
      chk("lat_e0", {31'd0, out_valid}, 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("lat_early", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_sum", {16'd0, sum}, {16'd0, e.s});
      chk("lat_cout", {31'd0, cout}, {31'd0, e.c});
      chk("lat_ovf", {31'd0, ovf}, {31'd0, e.o});
      @(posedge clk);
      #1;
      chk("lat_pulse", {31'd0, out_valid}, 32'd0);
   endtask

   // scoreboard: every valid output is matched against the queue head
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         run_q++;
         if (run_q > max_run) max_run = run_q;
         n_cmp++;
         assert (sbq.size() != 0) else begin
            n_bad++;
            $error("FAIL unexpected_beat got=%h exp=none", sum);
         end
         if (sbq.size() != 0) begin
            e = sbq[0];
            n_cmp++;
            assert ({sum, cout, ovf} === e) else begin
               n_bad++;
               $error("FAIL result got=%h/%b/%b exp=%h/%b/%b",
                      sum, cout, ovf, e.s, e.c, e.o);
            end
            if (out_ready === 1'b1) void'(sbq.pop_front());
         end
      end else begin
         run_q = 0;
      end
   end

   initial begin
      logic [17:0] hs;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      #1 rst_n  = 1'b0;
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic add with exact latency
      lat_beat(16'h1234, 16'h1111, 1'b0, 1'b0, mk(16'h2345, 1'b0, 1'b0));
      drain();

      // carry chain, signed overflow and subtract corners
      put(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0));
      put(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
      put(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
      put(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
      in_valid = 1'b0;
      drain();

      // 32 back-to-back random beats, one result per cycle
      max_run = 0;
      for (int i = 0; i < 32; i++) put_rand();
      in_valid = 1'b0;
      drain();
      chk("stream_run", max_run, 32);

      // backpressure: 3-cycle output stall in a 10-beat stream
      for (int i = 0; i < 10; i++) begin
         put_rand();
         if (i == 4) begin
            out_ready = 1'b0;
            in_valid  = 1'b0;
            @(negedge clk);
            hs = {sum, cout, ovf};
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            repeat (2) begin
               @(negedge clk);
               chk("bp_hold", {14'd0, sum, cout, ovf}, {14'd0, hs});
               chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      end
      in_valid = 1'b0;
      drain();

      // reset with beats in flight
      for (int i = 0; i < 4; i++) put_rand();
      in_valid = 1'b0;
      #1;
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_async_sum", {16'd0, sum}, 32'd0);
      sbq.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
         chk("no_stale", {31'd0, out_valid}, 32'd0);
      end
      lat_beat(16'h4000, 16'h4000, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
